data_cache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache between the memory access stage and the system bus.

---
 rtl/data_cache_if.sv | 40 ++++
 rtl/data_cache.sv | 183 ++++++++++++++++++
 tb/tb_data_cache.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Pipeline-side and bus-side signals of the data cache.
// slave: the cache view; master: the stage/bus environment view.
interface data_cache_if;
  logic [31:0] dmem_address_i;
  logic        dmem_read_i;
  logic        dmem_write_i;
  logic [3:0]  dmem_sel_i;
  logic [31:0] dmem_data_i;
  logic [31:0] dmem_data_o;
  logic        dmem_data_ready_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  modport slave (
    input  dmem_address_i, dmem_read_i,
    input  dmem_write_i, dmem_sel_i,
    input  dmem_data_i,
    output dmem_data_o, dmem_data_ready_o,
    output bus_req_o, bus_we_o,
    output bus_addr_o, bus_sel_o,
    output bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport master (
    output dmem_address_i, dmem_read_i,
    output dmem_write_i, dmem_sel_i,
    output dmem_data_i,
    input  dmem_data_o, dmem_data_ready_o,
    input  bus_req_o, bus_we_o,
    input  bus_addr_o, bus_sel_o,
    input  bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Loads fill whole lines over the word bus; stores go straight out.
module data_cache #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input logic        clock_i,
  input logic        reset_n_i,
  data_cache_if.slave io
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int AW    = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_OFF =
    OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    RESPOND,
    WRITE
  } state_t;

  state_t               state_q;
  logic [31:0]          addr_q;
  logic [OFF_W-1:0]     fill_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             ack;
  logic             load_hit;
  logic [31:0]      rd_word;

  logic             arr_we;
  logic [AW-1:0]    arr_addr;
  logic [31:0]      arr_wdata;
  logic             tag_we;

  logic             unused_ok;

  assign idx = addr_q[OFF_W+2 +: IDX_W];
  assign off = addr_q[2 +: OFF_W];
  assign tag = addr_q[31 -: TAG_W];
  assign unused_ok = ^addr_q[1:0];

  assign hit = valid_q[idx] && (tag_q[idx] == tag);
  assign ack = io.bus_ack_i && io.bus_req_o;
  assign rd_word = data_q[{idx, off}];

  assign load_hit = (state_q == LOOKUP)
                 && !io.dmem_write_i && hit;

  assign io.dmem_data_o = rd_word;
  assign io.dmem_data_ready_o =
    load_hit
    || (state_q == RESPOND)
    || ((state_q == WRITE) && ack);

  assign tag_we = (state_q == FILL) && ack
               && (fill_q == LAST_OFF);

  // Array write port: store-hit byte merge or fill word.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = {idx, off};
    arr_wdata = rd_word;
    unique case (1'b1)
      (state_q == LOOKUP) && io.dmem_write_i && hit: begin
        arr_we = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (io.dmem_sel_i[b]) begin
            arr_wdata[8*b +: 8] = io.dmem_data_i[8*b +: 8];
          end
        end
      end
      (state_q == FILL) && ack: begin
        arr_we    = 1'b1;
        arr_addr  = {idx, fill_q};
        arr_wdata = io.bus_rdata_i;
      end
      default: ;
    endcase
  end

  // Tag and data storage; validity lives in the FSM.
  always_ff @(posedge clock_i) begin
    if (arr_we) data_q[arr_addr] <= arr_wdata;
    if (tag_we) tag_q[idx] <= tag;
  end

  // Control FSM with registered bus outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      fill_q         <= '0;
      valid_q        <= '0;
      io.bus_req_o   <= 1'b0;
      io.bus_we_o    <= 1'b0;
      io.bus_addr_o  <= '0;
      io.bus_sel_o   <= '0;
      io.bus_wdata_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.dmem_read_i) begin
            addr_q  <= io.dmem_address_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (io.dmem_write_i) begin
            io.bus_req_o   <= 1'b1;
            io.bus_we_o    <= 1'b1;
            io.bus_addr_o  <= addr_q;
            io.bus_sel_o   <= io.dmem_sel_i;
            io.bus_wdata_o <= io.dmem_data_i;
            state_q        <= WRITE;
          end else if (hit) begin
            if (io.dmem_read_i) begin
              addr_q  <= io.dmem_address_i;
              state_q <= LOOKUP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            valid_q[idx]   <= 1'b0;
            fill_q         <= '0;
            io.bus_req_o   <= 1'b1;
            io.bus_we_o    <= 1'b0;
            io.bus_sel_o   <= 4'b1111;
            io.bus_wdata_o <= '0;
            io.bus_addr_o  <=
              {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            state_q        <= FILL;
          end
        end
        FILL: begin
          if (ack) begin
            if (fill_q == LAST_OFF) begin
              io.bus_req_o <= 1'b0;
              valid_q[idx] <= 1'b1;
              state_q      <= RESPOND;
            end else begin
              fill_q        <= fill_q + OFF_W'(1);
              io.bus_addr_o <= io.bus_addr_o + 32'd4;
            end
          end
        end
        RESPOND: begin
          if (io.dmem_read_i) begin
            addr_q  <= io.dmem_address_i;
            state_q <= LOOKUP;
          end else begin
            state_q <= IDLE;
          end
        end
        WRITE: begin
          if (ack) begin
            io.bus_req_o <= 1'b0;
            io.bus_we_o  <= 1'b0;
            if (io.dmem_read_i) begin
              addr_q  <= io.dmem_address_i;
              state_q <= LOOKUP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed requests,
// a bus responder checking bus cycles and a ready monitor.
module tb_data_cache;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  data_cache_if dif();

  data_cache #(
    .NUM_LINES(64),
    .LINE_WORDS(4)
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .io(dif)
  );

  typedef struct {
    bit          load;
    logic [31:0] data;
    int          kind;
  } dexp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bexp_t;

  dexp_t dq[$];
  bexp_t bq[$];

  logic [31:0] mem [logic [31:0]];
  int   acks;
  int   ack_cyc;
  int   rdy_cyc;
  bit   stray;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] a,
                     logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a + 32'h1000_0000;
  endfunction

  // Bus responder: acks every other cycle, checks each cycle.
  always @(negedge clk) begin
    if (dif.bus_ack_i) begin
      dif.bus_ack_i = 1'b0;
    end else if (stray) begin
      dif.bus_ack_i = 1'b1;
      stray = 1'b0;
    end else if (rst_n && dif.bus_req_o) begin
      bexp_t e;
      logic [31:0] w;
      dif.bus_ack_i = 1'b1;
      ack_cyc = cyc;
      acks++;
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got addr %h",
                 dif.bus_addr_o);
      end else begin
        e = bq.pop_front();
        chk("bus_we", 32'(dif.bus_we_o), 32'(e.we));
        chk("bus_addr", dif.bus_addr_o, e.addr);
        chk("bus_sel", 32'(dif.bus_sel_o), 32'(e.sel));
        if (e.we) chk("bus_wdata", dif.bus_wdata_o, e.wdata);
      end
      if (dif.bus_we_o) begin
        w = rd(dif.bus_addr_o);
        for (int b = 0; b < 4; b++)
          if (dif.bus_sel_o[b])
            w[8*b +: 8] = dif.bus_wdata_o[8*b +: 8];
        mem[dif.bus_addr_o] = w;
      end else begin
        dif.bus_rdata_i = rd(dif.bus_addr_o);
      end
    end
  end

  // Ready monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    #2;
    if (rst_n && dif.dmem_data_ready_o) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got 1 expected 0");
      end else begin
        dexp_t e;
        e = dq.pop_front();
        if (e.load) chk("load_data", dif.dmem_data_o, e.data);
        if (e.kind == 1)
          chk("fill_latency", cyc - ack_cyc, 1);
        if (e.kind == 2)
          chk("back_to_back", cyc - rdy_cyc, 1);
      end
      rdy_cyc = cyc;
    end
  end

  task automatic push_bus(logic we, logic [31:0] a,
                          logic [3:0] s, logic [31:0] d);
    bexp_t e;
    e.we = we;
    e.addr = a;
    e.sel = s;
    e.wdata = d;
    bq.push_back(e);
  endtask

  task automatic push_fill(logic [31:0] base);
    for (int i = 0; i < 4; i++)
      push_bus(1'b0, base + 32'(4 * i), 4'b1111, '0);
  endtask

  task automatic req_cycle(logic [31:0] a);
    @(negedge clk);
    dif.dmem_read_i = 1'b1;
    dif.dmem_address_i = a;
  endtask

  task automatic data_cycle(logic we, logic [3:0] s,
                            logic [31:0] d,
                            logic [31:0] exp_data, int kind,
                            bit chain, logic [31:0] naddr);
    dexp_t e;
    bit seen;
    @(negedge clk);
    dif.dmem_read_i = 1'b0;
    dif.dmem_write_i = we;
    dif.dmem_sel_i = s;
    dif.dmem_data_i = d;
    e.load = !we;
    e.data = exp_data;
    e.kind = kind;
    dq.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (dif.dmem_data_ready_o) begin
        seen = 1'b1;
        if (chain) begin
          dif.dmem_read_i = 1'b1;
          dif.dmem_address_i = naddr;
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic load(logic [31:0] a, logic [31:0] x,
                      int kind);
    req_cycle(a);
    data_cycle(1'b0, 4'b0000, '0, x, kind, 1'b0, '0);
  endtask

  initial begin
    int base;
    bit hit2;
    cyc = 0;
    checks = 0;
    errors = 0;
    acks = 0;
    ack_cyc = 0;
    rdy_cyc = 0;
    stray = 1'b0;
    rst_n = 1'b0;
    dif.dmem_address_i = '0;
    dif.dmem_read_i = 1'b0;
    dif.dmem_write_i = 1'b0;
    dif.dmem_sel_i = '0;
    dif.dmem_data_i = '0;
    dif.bus_rdata_i = '0;
    dif.bus_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(dif.dmem_data_ready_o), 0);
    chk("rst_req", 32'(dif.bus_req_o), 0);
    chk("rst_we", 32'(dif.bus_we_o), 0);
    chk("rst_sel", 32'(dif.bus_sel_o), 0);
    chk("rst_addr", dif.bus_addr_o, 0);
    chk("rst_wdata", dif.bus_wdata_o, 0);
    rst_n = 1'b1;

    // 1: cold miss fills the line from word 0.
    push_fill(32'h100);
    load(32'h100, 32'h1000_0100, 1);

    // 2: hit in the filled line, no bus traffic.
    base = acks;
    load(32'h108, 32'h1000_0108, 0);
    chk("hit_no_bus", 32'(acks - base), 0);

    // 3: store hit merges byte 1, then reload.
    push_bus(1'b1, 32'h104, 4'b0010, 32'hAABB_CCDD);
    req_cycle(32'h104);
    data_cycle(1'b1, 4'b0010, 32'hAABB_CCDD,
               '0, 0, 1'b0, '0);
    base = acks;
    load(32'h104, 32'h1000_CC04, 0);
    chk("merge_no_bus", 32'(acks - base), 0);

    // 4: store miss does not allocate.
    push_bus(1'b1, 32'h2000, 4'b1111, 32'h1122_3344);
    req_cycle(32'h2000);
    data_cycle(1'b1, 4'b1111, 32'h1122_3344,
               '0, 0, 1'b0, '0);
    push_fill(32'h2000);
    load(32'h2000, 32'h1122_3344, 1);

    // Stray ack with no bus cycle must be ignored.
    stray = 1'b1;
    repeat (3) @(negedge clk);

    // 5: back-to-back hits and fill followed by hit.
    req_cycle(32'h10C);
    data_cycle(1'b0, 4'b0000, '0, 32'h1000_010C, 0,
               1'b1, 32'h100);
    data_cycle(1'b0, 4'b0000, '0, 32'h1000_0100, 2,
               1'b0, '0);
    push_fill(32'h200);
    req_cycle(32'h200);
    data_cycle(1'b0, 4'b0000, '0, 32'h1000_0200, 1,
               1'b1, 32'h204);
    data_cycle(1'b0, 4'b0000, '0, 32'h1000_0204, 2,
               1'b0, '0);

    // Flushed store acts as a load and is never written.
    base = acks;
    req_cycle(32'h104);
    data_cycle(1'b0, 4'b1111, 32'hDEAD_BEEF,
               32'h1000_CC04, 0, 1'b0, '0);
    chk("flush_no_bus", 32'(acks - base), 0);

    // 6: reset after two fill acks aborts the fill.
    push_bus(1'b0, 32'h300, 4'b1111, '0);
    push_bus(1'b0, 32'h304, 4'b1111, '0);
    base = acks;
    req_cycle(32'h300);
    @(negedge clk);
    dif.dmem_read_i = 1'b0;
    dif.dmem_write_i = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < 40 && !hit2; i++) begin
      #1;
      if (acks - base >= 2) hit2 = 1'b1;
      else @(negedge clk);
    end
    chk("two_acks_seen", 32'(hit2), 1);
    @(posedge clk);
    #3;
    chk("pre_rst_req", 32'(dif.bus_req_o), 1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(dif.bus_req_o), 0);
    chk("async_ready", 32'(dif.dmem_data_ready_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_fill(32'h300);
    load(32'h300, 32'h1000_0300, 1);

    repeat (4) @(negedge clk);
    chk("bus_queue_empty", 32'(bq.size()), 0);
    chk("ready_queue_empty", 32'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
